med_dose_scheduler: RTL and testbench
=====================================

Name: med_dose_scheduler

Overview:
Schedules medication reminders. Keeps a time-of-day counter and a programmable table of NUM_SLOTS dose slots, each holding a time and an enable. When a slot's time matches the current time, the slot is latched as pending. Pending slots are arbitrated one at a time into an alert/snooze/acknowledge sequence, and each outcome (taken or missed) is handed to the downstream logger over a valid/ready event interface.

Parameters:
NUM_SLOTS, 8, number of dose slots (power of 2, max 16)
SLOT_W, 3, slot index width, equal to log2(NUM_SLOTS)
TIME_W, 11, time-of-day width
DAY_TICKS, 1440, minute ticks per day; time wraps DAY_TICKS-1 -> 0
TICK_DIV, 16, clk cycles per minute tick
ALERT_TICKS, 15, ticks an alert may stay unanswered before it is declared missed (1..255)
SNOOZE_TICKS, 5, length of one snooze in ticks (1..255)
MAX_SNOOZE, 2, snoozes allowed per dose

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cfg_we  in  1  slot table write strobe
cfg_addr  in  SLOT_W  slot to write
cfg_time  in  TIME_W  dose time for the slot
cfg_en  in  1  slot enable
time_set  in  1  load time_now from time_val
time_val  in  TIME_W  time value to load
ack  in  1  user confirms the dose was taken (1-cycle pulse)
snooze  in  1  user requests a snooze (1-cycle pulse)
alarm  out  1  alert is active
alarm_slot  out  SLOT_W  slot being alerted
busy  out  1  FSM is not in IDLE
pending  out  NUM_SLOTS  due-but-unserviced bitmap
time_now  out  TIME_W  current time of day
evt_valid  out  1  event to logger is valid
evt_ready  in  1  logger accepts the event
evt_slot  out  SLOT_W  slot the event refers to
evt_taken  out  1  1 = taken, 0 = missed
evt_time  out  TIME_W  time_now when the dose was resolved

Behaviour:
- Reset: all outputs 0; prescaler, timers, snooze count, pending and every slot time/enable cleared; FSM in IDLE. A reset mid-sequence drops the current dose with no event.
- Prescaler counts 0..TICK_DIV-1. On the cycle it reaches TICK_DIV-1 it emits tick and time_now increments, wrapping DAY_TICKS-1 -> 0.
- time_set loads time_now = time_val and clears the prescaler. A tick in the same cycle is discarded. A loaded time does not trigger a due match.
- Due detect: in the cycle after a tick, pending[i] is set for every slot with en=1 and time==time_now. A bit that is already set stays set; there is no counting.
- cfg_we writes the slot and clears its pending bit. If the write and a due set hit the same slot in the same cycle, the write wins.
- FSM states and transitions:
  - IDLE: if pending is nonzero, select the lowest set index, clear that bit, latch it into cur_slot, set timer=0 and snooze_cnt=0, go to ALERT. Service starts one cycle after the pending bit is set.
  - ALERT: alarm=1, alarm_slot=cur_slot, timer increments on each tick. Checks in priority order:
    - ack -> TAKEN.
    - Else snooze with snooze_cnt<MAX_SNOOZE -> snooze_cnt+1, timer=0, go to SNOOZE.
    - A snooze at the limit is ignored.
    - Else timer==ALERT_TICKS -> MISSED.
    - ack and snooze in the same cycle: ack wins.
  - SNOOZE: alarm=0, timer increments on each tick.
    - ack -> TAKEN.
    - timer==SNOOZE_TICKS -> timer=0, go to ALERT.
  - REPORT (entered from TAKEN or MISSED): register evt_slot, evt_taken and evt_time=time_now; hold evt_valid=1 with stable fields until evt_ready.
    - On the handshake cycle (valid and ready) go to IDLE; evt_valid=0 next cycle.
    - ack and snooze are ignored in REPORT and IDLE.
- Pending keeps accumulating during ALERT, SNOOZE and REPORT and is served strictly lowest index first. A slot that comes due again while it is being serviced sets its pending bit again.
- Slot reprogramming during service does not affect the current dose.
- busy=1 in every state except IDLE. alarm is registered.

Test Plan:
1. TICK_DIV=4. Slot 2 programmed with time 5, en=1; time_now=0. -> pending[2] set the cycle after time_now becomes 5; alarm=1 with alarm_slot=2 the next cycle. ack -> evt_valid=1, evt_slot=2, evt_taken=1, evt_time=5. Hold evt_ready=0 for 3 cycles -> fields stay stable. evt_ready=1 -> busy=0.
2. Timeout, ALERT_TICKS=3. Slot 0 at time 5, no ack. -> evt_taken=0 with evt_time=8.
3. Arbitration. Slots 4 and 1 both at time 10. -> alarm_slot=1 first, with pending=0x10 during service. After the event handshake, alarm_slot=4.
4. Snooze, MAX_SNOOZE=2 and SNOOZE_TICKS=2. Snooze twice -> alarm drops, then returns after 2 ticks each time. A third snooze is ignored. Timeout -> missed event. Separately, ack during SNOOZE -> taken event.
5. Wrap and collisions. time_set with time_val=1439, slot 3 at time 0. -> after one tick time_now=0 and alarm_slot=3. cfg_we to slot 3 in the due cycle -> pending[3] stays 0. time_set with time_val=0 on a slot at time 0 -> no due.
6. Reset. Assert rst_n=0 mid-ALERT and mid-REPORT. -> alarm, evt_valid, pending, busy and time_now are 0; no event is issued. A slot does not fire afterwards until it is reprogrammed.

Source files
------------

// File: rtl/med_dose_scheduler.sv
// Medication reminder scheduler: minute clock, programmable dose slots, and an
// alert/snooze/acknowledge sequence whose outcome goes to a valid/ready event port.
module med_dose_scheduler #(
  parameter int NUM_SLOTS    = 8,
  parameter int SLOT_W       = 3,
  parameter int TIME_W       = 11,
  parameter int DAY_TICKS    = 1440,
  parameter int TICK_DIV     = 16,
  parameter int ALERT_TICKS  = 15,
  parameter int SNOOZE_TICKS = 5,
  parameter int MAX_SNOOZE   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [SLOT_W-1:0]    cfg_addr,
  input  logic [TIME_W-1:0]    cfg_time,
  input  logic                 cfg_en,
  input  logic                 time_set,
  input  logic [TIME_W-1:0]    time_val,
  input  logic                 ack,
  input  logic                 snooze,
  output logic                 alarm,
  output logic [SLOT_W-1:0]    alarm_slot,
  output logic                 busy,
  output logic [NUM_SLOTS-1:0] pending,
  output logic [TIME_W-1:0]    time_now,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [SLOT_W-1:0]    evt_slot,
  output logic                 evt_taken,
  output logic [TIME_W-1:0]    evt_time
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SC_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ALERT, S_SNOOZE, S_TAKEN, S_MISSED, S_REPORT} state_t;

  state_t              state;
  logic [PS_W-1:0]     presc;
  logic                tick;
  logic                tick_d;
  logic [TIME_W-1:0]   slot_time [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_en;
  logic [NUM_SLOTS-1:0] due;
  logic [NUM_SLOTS-1:0] pend_nxt;
  logic                pick_vld;
  logic [SLOT_W-1:0]   pick;
  logic [SLOT_W-1:0]   cur_slot;
  logic [7:0]          timer;
  logic [SC_W-1:0]     snooze_cnt;

  // A time load discards any tick landing in the same cycle.
  assign tick = (presc == PS_W'(TICK_DIV - 1)) && !time_set;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      time_now <= '0;
      tick_d   <= 1'b0;
    end else if (time_set) begin
      presc    <= '0;
      time_now <= time_val;
      tick_d   <= 1'b0;
    end else begin
      tick_d <= tick;
      if (tick) begin
        presc    <= '0;
        time_now <= (time_now == TIME_W'(DAY_TICKS - 1)) ? '0 : time_now + TIME_W'(1);
      end else begin
        presc <= presc + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_time[i] <= '0;
      slot_en <= '0;
    end else if (cfg_we) begin
      slot_time[cfg_addr] <= cfg_time;
      slot_en[cfg_addr]   <= cfg_en;
    end
  end

  always_comb begin
    due = '0;
    if (tick_d)
      for (int i = 0; i < NUM_SLOTS; i++)
        due[i] = slot_en[i] && (slot_time[i] == time_now);
  end

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (pending[i]) begin
        pick_vld = 1'b1;
        pick     = SLOT_W'(i);
      end
  end

  // A fresh due match re-arms a slot even as it is taken into service; a table write beats both.
  always_comb begin
    pend_nxt = pending;
    if (state == S_IDLE && pick_vld) pend_nxt[pick] = 1'b0;
    pend_nxt = pend_nxt | due;
    if (cfg_we) pend_nxt[cfg_addr] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pend_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur_slot   <= '0;
      timer      <= '0;
      snooze_cnt <= '0;
      alarm      <= 1'b0;
      alarm_slot <= '0;
      evt_valid  <= 1'b0;
      evt_slot   <= '0;
      evt_taken  <= 1'b0;
      evt_time   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            cur_slot   <= pick;
            timer      <= '0;
            snooze_cnt <= '0;
            alarm      <= 1'b1;
            alarm_slot <= pick;
            state      <= S_ALERT;
          end
        end
        S_ALERT: begin
          if (ack) begin
            alarm <= 1'b0;
            state <= S_TAKEN;
          end else if (snooze && (snooze_cnt < SC_W'(MAX_SNOOZE))) begin
            snooze_cnt <= snooze_cnt + SC_W'(1);
            timer      <= '0;
            alarm      <= 1'b0;
            state      <= S_SNOOZE;
          end else if (timer == 8'(ALERT_TICKS)) begin
            alarm <= 1'b0;
            state <= S_MISSED;
          end else if (tick) begin
            timer <= timer + 8'd1;
          end
        end
        S_SNOOZE: begin
          if (ack) begin
            state <= S_TAKEN;
          end else if (timer == 8'(SNOOZE_TICKS)) begin
            timer <= '0;
            alarm <= 1'b1;
            state <= S_ALERT;
          end else if (tick) begin
            timer <= timer + 8'd1;
          end
        end
        S_TAKEN, S_MISSED: begin
          evt_valid <= 1'b1;
          evt_slot  <= cur_slot;
          evt_taken <= (state == S_TAKEN);
          evt_time  <= time_now;
          state     <= S_REPORT;
        end
        S_REPORT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_med_dose_scheduler.sv
// Self-checking bench for med_dose_scheduler: directed scenarios plus randomized
// dose rounds checked against a minute-clock and service-order model.
module tb_med_dose_scheduler;
  localparam int NS = 8, SW = 3, TW = 11, DAY = 1440, TD = 4, AT = 3, ST = 2, MS = 2;

  logic clk, rst_n, cfg_we, cfg_en, time_set, ack, snooze, evt_ready;
  logic [SW-1:0] cfg_addr, alarm_slot, evt_slot;
  logic [TW-1:0] cfg_time, time_val, time_now, evt_time;
  logic alarm, busy, evt_valid, evt_taken;
  logic [NS-1:0] pending;
  int n_cmp = 0, n_err = 0;

  med_dose_scheduler #(.NUM_SLOTS(NS), .SLOT_W(SW), .TIME_W(TW), .DAY_TICKS(DAY),
    .TICK_DIV(TD), .ALERT_TICKS(AT), .SNOOZE_TICKS(ST), .MAX_SNOOZE(MS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_time(cfg_time),
    .cfg_en(cfg_en), .time_set(time_set), .time_val(time_val), .ack(ack), .snooze(snooze),
    .alarm(alarm), .alarm_slot(alarm_slot), .busy(busy), .pending(pending),
    .time_now(time_now), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_slot(evt_slot), .evt_taken(evt_taken), .evt_time(evt_time));

  initial clk = 0;
  always #5 clk = ~clk;

  // Minute-clock model: one minute per TD cycles since the last load or reset.
  int mt_base, mt_k;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin mt_base <= 0; mt_k <= 0; end
    else if (time_set) begin mt_base <= int'(time_val); mt_k <= 0; end
    else mt_k <= mt_k + 1;
  function automatic int mtime(int back);
    return (mt_base + (mt_k - back) / TD) % DAY;
  endfunction

  task automatic step(int n); repeat (n) @(negedge clk); endtask
  task automatic do_reset;
    rst_n = 0; cfg_we = 0; cfg_addr = '0; cfg_time = '0; cfg_en = 0;
    time_set = 0; time_val = '0; ack = 0; snooze = 0; evt_ready = 1;
    step(2); rst_n = 1; step(1);
  endtask
  task automatic prog(int s, int t, bit en);
    cfg_we = 1; cfg_addr = SW'(s); cfg_time = TW'(t); cfg_en = en; step(1); cfg_we = 0;
  endtask
  task automatic set_time(int v);
    time_set = 1; time_val = TW'(v); step(1); time_set = 0;
  endtask
  task automatic pulse_ack; ack = 1; step(1); ack = 0; endtask
  task automatic pulse_snooze; snooze = 1; step(1); snooze = 0; endtask
  task automatic wait_alarm(output bit ok);
    for (int i = 0; i < 300 && !alarm; i++) step(1);
    ok = alarm;
  endtask
  task automatic wait_evt(output bit ok);
    for (int i = 0; i < 300 && !evt_valid; i++) step(1);
    ok = evt_valid;
  endtask

  task automatic test_reset;
    rst_n = 0; step(1);
    n_cmp++; if ({alarm, busy, evt_valid, evt_taken, pending, time_now, alarm_slot, evt_slot, evt_time} !== '0) begin
      n_err++; $display("FAIL reset_outputs: alarm=%b busy=%b evt_valid=%b pending=%h time=%0d want all 0", alarm, busy, evt_valid, pending, time_now); end
    do_reset;
  endtask

  task automatic test_taken;
    bit ok;
    do_reset; prog(2, 5, 1); set_time(0);
    for (int i = 0; i < 100 && time_now != 5; i++) step(1);
    n_cmp++; if (time_now !== 11'd5 || pending !== 8'h00) begin n_err++; $display("FAIL t1_reach5: time=%0d pending=%h want 5/00", time_now, pending); end
    step(1);
    n_cmp++; if (pending !== 8'h04 || alarm !== 1'b0) begin n_err++; $display("FAIL t1_pending: pending=%h alarm=%b want 04/0", pending, alarm); end
    step(1);
    n_cmp++; if (alarm !== 1'b1 || alarm_slot !== 3'd2 || pending !== 8'h00 || busy !== 1'b1) begin
      n_err++; $display("FAIL t1_alarm: alarm=%b slot=%0d pending=%h busy=%b want 1/2/00/1", alarm, alarm_slot, pending, busy); end
    evt_ready = 0; pulse_ack; wait_evt(ok);
    n_cmp++; if (!ok || evt_slot !== 3'd2 || evt_taken !== 1'b1 || evt_time !== 11'd5) begin
      n_err++; $display("FAIL t1_event: valid=%b slot=%0d taken=%b time=%0d want 1/2/1/5", ok, evt_slot, evt_taken, evt_time); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_cmp++; if (evt_valid !== 1'b1 || evt_slot !== 3'd2 || evt_taken !== 1'b1 || evt_time !== 11'd5) begin
        n_err++; $display("FAIL t1_hold: valid=%b slot=%0d taken=%b time=%0d want 1/2/1/5", evt_valid, evt_slot, evt_taken, evt_time); end
    end
    evt_ready = 1; step(1);
    n_cmp++; if (evt_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t1_release: valid=%b busy=%b want 0/0", evt_valid, busy); end
  endtask

  task automatic test_timeout;
    bit ok;
    do_reset; prog(0, 5, 1); set_time(0);
    wait_alarm(ok);
    n_cmp++; if (!ok || alarm_slot !== 3'd0) begin n_err++; $display("FAIL t2_alarm: alarm=%b slot=%0d want 1/0", ok, alarm_slot); end
    wait_evt(ok);
    n_cmp++; if (!ok || evt_slot !== 3'd0 || evt_taken !== 1'b0 || evt_time !== 11'd8) begin
      n_err++; $display("FAIL t2_missed: valid=%b slot=%0d taken=%b time=%0d want 1/0/0/8", ok, evt_slot, evt_taken, evt_time); end
    step(1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t2_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_arbitration;
    bit ok;
    do_reset; prog(4, 10, 1); prog(1, 10, 1); set_time(8);
    wait_alarm(ok);
    n_cmp++; if (!ok || alarm_slot !== 3'd1 || pending !== 8'h10) begin
      n_err++; $display("FAIL t3_first: alarm=%b slot=%0d pending=%h want 1/1/10", ok, alarm_slot, pending); end
    pulse_ack; wait_evt(ok);
    n_cmp++; if (!ok || evt_slot !== 3'd1 || evt_taken !== 1'b1) begin n_err++; $display("FAIL t3_evt1: slot=%0d taken=%b want 1/1", evt_slot, evt_taken); end
    step(1); wait_alarm(ok);
    n_cmp++; if (!ok || alarm_slot !== 3'd4 || pending !== 8'h00) begin
      n_err++; $display("FAIL t3_second: alarm=%b slot=%0d pending=%h want 1/4/00", ok, alarm_slot, pending); end
    pulse_ack; wait_evt(ok);
    n_cmp++; if (!ok || evt_slot !== 3'd4) begin n_err++; $display("FAIL t3_evt2: slot=%0d want 4", evt_slot); end
    step(1);
  endtask

  task automatic test_snooze;
    bit ok; int t0, t_ret;
    do_reset; prog(5, 3, 1); set_time(2);
    wait_alarm(ok);
    t_ret = 0;
    for (int s = 0; s < MS; s++) begin
      pulse_snooze;
      n_cmp++; if (alarm !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL t4_snooze_drop%0d: alarm=%b busy=%b want 0/1", s, alarm, busy); end
      t0 = int'(time_now);
      wait_alarm(ok); t_ret = int'(time_now);
      n_cmp++; if (!ok || t_ret != (t0 + ST) % DAY) begin n_err++; $display("FAIL t4_snooze_back%0d: alarm=%b time=%0d want 1/%0d", s, ok, t_ret, (t0 + ST) % DAY); end
    end
    pulse_snooze;
    n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL t4_third_snooze: alarm=%b want 1", alarm); end
    wait_evt(ok);
    n_cmp++; if (!ok || evt_slot !== 3'd5 || evt_taken !== 1'b0 || int'(evt_time) != (t_ret + AT) % DAY) begin
      n_err++; $display("FAIL t4_missed: slot=%0d taken=%b time=%0d want 5/0/%0d", evt_slot, evt_taken, evt_time, (t_ret + AT) % DAY); end
    step(1);
    prog(6, (int'(time_now) + 2) % DAY, 1); wait_alarm(ok);
    pulse_snooze; step(1);
    n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL t4_in_snooze: alarm=%b want 0", alarm); end
    pulse_ack; wait_evt(ok);
    n_cmp++; if (!ok || evt_slot !== 3'd6 || evt_taken !== 1'b1) begin n_err++; $display("FAIL t4_ack_snooze: slot=%0d taken=%b want 6/1", evt_slot, evt_taken); end
    step(1);
    prog(7, (int'(time_now) + 2) % DAY, 1); wait_alarm(ok);
    ack = 1; snooze = 1; step(1); ack = 0; snooze = 0;
    wait_evt(ok);
    n_cmp++; if (!ok || evt_slot !== 3'd7 || evt_taken !== 1'b1) begin n_err++; $display("FAIL t4_ack_wins: slot=%0d taken=%b want 7/1", evt_slot, evt_taken); end
    step(1);
  endtask

  task automatic test_wrap;
    bit ok; int n;
    do_reset; prog(3, 0, 1); set_time(DAY - 1);
    n = 0;
    while (n < 20 && time_now == 11'(DAY - 1)) begin step(1); n++; end
    n_cmp++; if (time_now !== 11'd0 || n != TD) begin n_err++; $display("FAIL t5_wrap: time=%0d cycles=%0d want 0/%0d", time_now, n, TD); end
    wait_alarm(ok);
    n_cmp++; if (!ok || alarm_slot !== 3'd3) begin n_err++; $display("FAIL t5_alarm: alarm=%b slot=%0d want 1/3", ok, alarm_slot); end
    pulse_ack; wait_evt(ok); step(1);
    set_time(DAY - 1);
    for (int i = 0; i < 20 && time_now != 0; i++) step(1);
    prog(3, 0, 1);
    n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL t5_write_wins: pending=%h want 00", pending); end
    step(3);
    n_cmp++; if (busy !== 1'b0 || alarm !== 1'b0) begin n_err++; $display("FAIL t5_no_service: busy=%b alarm=%b want 0/0", busy, alarm); end
    set_time(0); step(6);
    n_cmp++; if (pending !== 8'h00 || busy !== 1'b0) begin n_err++; $display("FAIL t5_load_no_due: pending=%h busy=%b want 00/0", pending, busy); end
  endtask

  task automatic test_reset_mid;
    bit ok; int seen;
    do_reset; prog(1, 3, 1); set_time(2); wait_alarm(ok);
    rst_n = 0; #1;
    n_cmp++; if ({alarm, evt_valid, busy, pending, time_now} !== '0) begin
      n_err++; $display("FAIL t6_rst_alert: alarm=%b valid=%b busy=%b pending=%h time=%0d want 0", alarm, evt_valid, busy, pending, time_now); end
    step(1); rst_n = 1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin step(1); if (alarm || evt_valid || busy || pending != 0) seen++; end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL t6_quiet1: active cycles=%0d want 0", seen); end
    prog(1, (int'(time_now) + 2) % DAY, 1); wait_alarm(ok);
    evt_ready = 0; pulse_ack; wait_evt(ok);
    rst_n = 0; #1;
    n_cmp++; if ({alarm, evt_valid, busy, pending, time_now} !== '0) begin
      n_err++; $display("FAIL t6_rst_report: alarm=%b valid=%b busy=%b pending=%h time=%0d want 0", alarm, evt_valid, busy, pending, time_now); end
    step(1); rst_n = 1; evt_ready = 1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin step(1); if (alarm || evt_valid || busy || pending != 0) seen++; end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL t6_quiet2: active cycles=%0d want 0", seen); end
    prog(1, (int'(time_now) + 2) % DAY, 1); wait_alarm(ok);
    n_cmp++; if (!ok || alarm_slot !== 3'd1) begin n_err++; $display("FAIL t6_reprog: alarm=%b slot=%0d want 1/1", ok, alarm_slot); end
    pulse_ack; wait_evt(ok); step(1);
  endtask

  task automatic test_random;
    bit ok; int base, t, d, exp_t;
    bit [NS-1:0] en, remaining;
    bit took [NS];
    int dly [NS];
    for (int r = 0; r < 4; r++) begin
      do_reset;
      base = $urandom_range(0, DAY - 10); t = base + 3;
      en = NS'($urandom_range(1, (1 << NS) - 1));
      for (int i = 0; i < NS; i++) begin
        took[i] = 1'($urandom_range(0, 1)); dly[i] = $urandom_range(0, 6);
        prog(i, t, en[i]);
      end
      set_time(base);
      remaining = en;
      for (int s = 0; s < NS; s++) begin
        if (!en[s]) continue;
        wait_alarm(ok);
        remaining[s] = 1'b0;
        n_cmp++; if (!ok || alarm_slot !== SW'(s) || pending !== remaining) begin
          n_err++; $display("FAIL rnd_alarm: alarm=%b slot=%0d pending=%h want 1/%0d/%h", ok, alarm_slot, pending, s, remaining); end
        evt_ready = 0;
        if (took[s]) begin step(dly[s]); pulse_ack; end
        wait_evt(ok);
        exp_t = mtime(1);
        n_cmp++; if (!ok || evt_slot !== SW'(s) || evt_taken !== took[s] || int'(evt_time) != exp_t) begin
          n_err++; $display("FAIL rnd_event: slot=%0d taken=%b time=%0d want %0d/%b/%0d", evt_slot, evt_taken, evt_time, s, took[s], exp_t); end
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
          step(1);
          n_cmp++; if (evt_valid !== 1'b1 || evt_slot !== SW'(s) || int'(evt_time) != exp_t) begin
            n_err++; $display("FAIL rnd_hold: valid=%b slot=%0d time=%0d want 1/%0d/%0d", evt_valid, evt_slot, evt_time, s, exp_t); end
        end
        evt_ready = 1; step(1);
      end
      step(2);
      n_cmp++; if (busy !== 1'b0 || pending !== 8'h00) begin n_err++; $display("FAIL rnd_done: busy=%b pending=%h want 0/00", busy, pending); end
    end
  endtask

  initial begin
    rst_n = 0; cfg_we = 0; cfg_addr = '0; cfg_time = '0; cfg_en = 0;
    time_set = 0; time_val = '0; ack = 0; snooze = 0; evt_ready = 1;
    test_reset;
    test_taken;
    test_timeout;
    test_arbitration;
    test_snooze;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
